glip_channel_arbiter: RTL
=========================

# glip_channel_arbiter

Shares the single GLIP FIFO stream between CHANNELS independent logic-side clients. Outbound: round-robin arbiter, collects up to MAX_BURST words from one client into a burst buffer and emits a header word plus payload to the GLIP fifo_out side. Inbound: parses the same framing from the GLIP fifo_in side and routes payload words to the addressed client. Sits between the GLIP backend toplevel and the user logic in clk_logic.

## Interface
- WIDTH, 16, word width of GLIP and client streams; must be >= 16
- CHANNELS, 4, number of clients; 1..256
- MAX_BURST, 8, max payload words per frame; 1..255
- clk_logic  in  1  logic clock; all flops rising-edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- tx_data  in  CHANNELS*WIDTH  client i outbound word at [i*WIDTH +: WIDTH]
- tx_valid  in  CHANNELS  client outbound valid
- tx_ready  out  CHANNELS  client outbound ready (one-hot or zero)
- fifo_out_data  out  WIDTH  framed word to GLIP fifo_out
- fifo_out_valid  out  1
- fifo_out_ready  in  1
- fifo_in_data  in  WIDTH  framed word from GLIP fifo_in
- fifo_in_valid  in  1
- fifo_in_ready  out  1
- rx_data  out  WIDTH  inbound payload word, shared by all clients
- rx_valid  out  CHANNELS  per-client inbound valid (one-hot or zero)
- rx_ready  in  CHANNELS  per-client inbound ready
- err_bad_channel  out  1  sticky; set on inbound frame with channel >= CHANNELS or length 0

## Operation
- Frame format: header word, then LEN payload words. Header [7:0] = LEN (1..MAX_BURST), [15:8] = channel id, [WIDTH-1:16] = 0.
- Handshake everywhere: transfer when valid & ready on a rising edge; valid holds data stable until accepted.
- Outbound FSM TX_IDLE / TX_COLLECT / TX_HEADER / TX_PAYLOAD:
  - TX_IDLE: if any tx_valid, grant g = first requester searching from (last_grant+1) mod CHANNELS; register g, cnt=0; -> TX_COLLECT. tx_ready all 0.
  - TX_COLLECT: tx_ready[g] = 1 while cnt < MAX_BURST. Each handshake writes buf[cnt], cnt++. Exit to TX_HEADER when cnt reaches MAX_BURST, or when tx_valid[g]=0 with cnt >= 1.
  - TX_HEADER: fifo_out_valid=1, fifo_out_data={0, g[7:0], cnt[7:0]}; on handshake idx=0 -> TX_PAYLOAD.
  - TX_PAYLOAD: fifo_out_valid=1, data=buf[idx]; on handshake idx++; handshake with idx==cnt-1 -> TX_IDLE, last_grant=g.
  - last_grant resets to CHANNELS-1, so first grant after reset searches from channel 0.
- Inbound FSM RX_HDR / RX_DATA / RX_DROP:
  - RX_HDR: fifo_in_ready=1. On handshake latch ch=[15:8], rem=[7:0]. rem==0 -> stay, set err. ch >= CHANNELS -> RX_DROP, set err. Else -> RX_DATA.
  - RX_DATA: combinational pass-through: rx_data=fifo_in_data, rx_valid[ch]=fifo_in_valid, fifo_in_ready=rx_ready[ch]. Each handshake rem--; at rem==1 handshake -> RX_HDR.
  - RX_DROP: fifo_in_ready=1, words discarded, rem counts down identically, rx_valid=0.
- Outbound and inbound are fully independent; both may transfer in the same cycle.
- err_bad_channel cleared only by reset.

## Timing
- Reset (async, rst_n low): TX_IDLE, RX_HDR, cnt/idx/rem=0, err=0. Outputs during reset: tx_ready=0, fifo_out_valid=0, fifo_out_data=0, rx_valid=0, rx_data=fifo_in_data (pass-through, don't-care), fifo_in_ready=1 (no word consumed while rst_n low since flops are held).
- Reset asserted mid-frame aborts both FSMs; buffered outbound words are lost; a partially received inbound frame's remainder is parsed as headers after release.
- Outbound latency: first client word accepted 2 cycles after tx_valid rises in TX_IDLE (1 cycle grant, accept in TX_COLLECT); header appears the cycle after collection ends; with fifo_out_ready=1, an N-word frame occupies 1+1+N+1+N cycles TX_IDLE to TX_IDLE.
- Outbound throughput stalls freely on fifo_out_ready=0; fifo_out_data held stable.
- Inbound adds zero latency in RX_DATA; header costs one cycle.
- A client dropping tx_valid mid-collection ends the burst; its next word waits for a later grant.

## Test plan
- Single client: channel 2 presents 3 words 0xA1,0xA2,0xA3 then drops valid, fifo_out_ready=1 -> fifo_out emits 0x0203, 0xA1, 0xA2, 0xA3; tx_ready[2] high exactly 3 handshake cycles.
- Burst cap: channel 0 holds valid with 10 words, MAX_BURST=8 -> header 0x0008 + 8 words, then (no other requester) header 0x0002 + remaining 2 words.
- Round-robin: channels 0,1,3 all valid continuously -> frame order 0,1,3,0,1,3; no client granted twice while another waits.
- Backpressure: fifo_out_ready toggles 1/0 every cycle during a 4-word frame -> data stable while stalled, all 5 words delivered in order, none duplicated.
- Inbound routing: inject 0x0102, 0xBEEF, 0xCAFE with rx_ready[1] low for 3 cycles -> fifo_in_ready follows rx_ready[1], rx_valid=0b0010, both words delivered to client 1 only.
- Errors/reset: inject header 0x0902 (CHANNELS=4) + 2 words -> words dropped, fifo_in_ready=1, err_bad_channel=1 stays set; then header 0x0000 -> ignored; assert rst_n low mid-outbound frame -> fifo_out_valid=0 immediately, err_bad_channel=0.

Source files
------------

// File: rtl/glip_channel_arbiter.sv
// glip_channel_arbiter: shares one GLIP FIFO stream between CHANNELS clients.
// Outbound: round-robin burst collector and framer.
// Inbound: frame parser and router to the addressed client.
// Ports:
//   clk_logic, rst_n          logic clock, async active-low reset
//   tx_data/valid/ready       client outbound streams (ready one-hot or zero)
//   fifo_out_data/valid/ready framed words to GLIP fifo_out
//   fifo_in_data/valid/ready  framed words from GLIP fifo_in
//   rx_data/valid/ready       inbound payload (data shared, valid one-hot)
//   err_bad_channel           sticky: bad channel id or zero length header
module glip_channel_arbiter #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk_logic,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] tx_data,
  input  logic [CHANNELS-1:0]       tx_valid,
  output logic [CHANNELS-1:0]       tx_ready,
  output logic [WIDTH-1:0]          fifo_out_data,
  output logic                      fifo_out_valid,
  input  logic                      fifo_out_ready,
  input  logic [WIDTH-1:0]          fifo_in_data,
  input  logic                      fifo_in_valid,
  output logic                      fifo_in_ready,
  output logic [WIDTH-1:0]          rx_data,
  output logic [CHANNELS-1:0]       rx_valid,
  input  logic [CHANNELS-1:0]       rx_ready,
  output logic                      err_bad_channel
);

  localparam int AW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_COLLECT,
    TX_HEADER,
    TX_PAYLOAD
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_DATA,
    RX_DROP
  } rx_state_e;

  // ---------------- outbound ----------------
  tx_state_e        tx_q, tx_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [7:0]       last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic [WIDTH-1:0] burst_q [DEPTH];
  logic             burst_we;

  logic             req_any;
  logic [7:0]       req_gnt;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;

  // First requester searching upward from the channel after last_q.
  always_comb begin : arb
    int c;
    c       = 0;
    req_any = 1'b0;
    req_gnt = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      c = (int'(last_q) + 1 + k) % CHANNELS;
      if (!req_any && tx_valid[c]) begin
        req_any = 1'b1;
        req_gnt = 8'(c);
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_q == 8'(i)) begin
        sel_data  = tx_data[i*WIDTH +: WIDTH];
        sel_valid = tx_valid[i];
      end
    end
  end

  always_comb begin
    tx_d           = tx_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    tx_ready       = '0;
    fifo_out_valid = 1'b0;
    fifo_out_data  = '0;
    burst_we       = 1'b0;
    unique case (tx_q)
      TX_IDLE: begin
        if (req_any) begin
          gnt_d = req_gnt;
          cnt_d = '0;
          tx_d  = TX_COLLECT;
        end
      end
      TX_COLLECT: begin
        for (int i = 0; i < CHANNELS; i++) begin
          tx_ready[i] = (gnt_q == 8'(i)) &&
                        (cnt_q < 8'(MAX_BURST));
        end
        if (sel_valid && (cnt_q < 8'(MAX_BURST))) begin
          burst_we = 1'b1;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_d == 8'(MAX_BURST)) tx_d = TX_HEADER;
        end else if (!sel_valid) begin
          // A grantee that withdrew before its first word gets no
          // empty frame; arbitration simply restarts.
          tx_d = (cnt_q != '0) ? TX_HEADER : TX_IDLE;
        end
      end
      TX_HEADER: begin
        fifo_out_valid       = 1'b1;
        fifo_out_data[15:8]  = gnt_q;
        fifo_out_data[7:0]   = cnt_q;
        if (fifo_out_ready) begin
          idx_d = '0;
          tx_d  = TX_PAYLOAD;
        end
      end
      TX_PAYLOAD: begin
        fifo_out_valid = 1'b1;
        fifo_out_data  = burst_q[idx_q[AW-1:0]];
        if (fifo_out_ready) begin
          if (idx_q == cnt_q - 8'd1) begin
            last_d = gnt_q;
            tx_d   = TX_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_logic or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= TX_IDLE;
      gnt_q  <= '0;
      last_q <= 8'(CHANNELS - 1);
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      tx_q   <= tx_d;
      gnt_q  <= gnt_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
    end
  end

  // Burst storage needs no reset: it is only read after being written.
  always_ff @(posedge clk_logic) begin
    if (burst_we) burst_q[cnt_q[AW-1:0]] <= sel_data;
  end

  // ---------------- inbound ----------------
  rx_state_e  rx_q, rx_d;
  logic [7:0] ch_q, ch_d;
  logic [7:0] rem_q, rem_d;
  logic       err_q, err_d;
  logic       route_ready;

  assign rx_data         = fifo_in_data;
  assign err_bad_channel = err_q;

  always_comb begin
    route_ready = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == 8'(i)) route_ready = rx_ready[i];
    end
  end

  always_comb begin
    rx_d          = rx_q;
    ch_d          = ch_q;
    rem_d         = rem_q;
    err_d         = err_q;
    fifo_in_ready = 1'b1;
    rx_valid      = '0;
    unique case (rx_q)
      RX_HDR: begin
        if (fifo_in_valid) begin
          ch_d  = fifo_in_data[15:8];
          rem_d = fifo_in_data[7:0];
          if (rem_d == '0) begin
            err_d = 1'b1;
          end else if (9'(ch_d) >= 9'(CHANNELS)) begin
            err_d = 1'b1;
            rx_d  = RX_DROP;
          end else begin
            rx_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        fifo_in_ready = route_ready;
        for (int i = 0; i < CHANNELS; i++) begin
          rx_valid[i] = fifo_in_valid && (ch_q == 8'(i));
        end
        if (fifo_in_valid && route_ready) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) rx_d = RX_HDR;
        end
      end
      RX_DROP: begin
        if (fifo_in_valid) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) rx_d = RX_HDR;
        end
      end
      default: rx_d = RX_HDR;
    endcase
  end

  always_ff @(posedge clk_logic or negedge rst_n) begin
    if (!rst_n) begin
      rx_q  <= RX_HDR;
      ch_q  <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      rx_q  <= rx_d;
      ch_q  <= ch_d;
      rem_q <= rem_d;
      err_q <= err_d;
    end
  end

endmodule
